deser3: RTL and testbench
=========================

Name: deser3

Overview:
- Serial-to-parallel companion to the 3-input reduction gates. It takes a 1-bit stream and assembles WIDTH-bit words, LSB first.
- Each completed word is presented on a valid/ready output port, together with its registered AND-reduction and OR-reduction.
- It sits between a serial source (switch/shift input) and parallel consumers such as the 3-input gate logic.

Parameters:
- WIDTH, 3, bits per assembled word (legal range 2..8).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous clear of the partial word; does not touch the output register.
- in_bit, input, 1, serial data bit.
- in_valid, input, 1, in_bit is valid this cycle.
- in_ready, output, 1, block accepts in_bit this cycle.
- out_data, output, WIDTH, assembled word; bit 0 is the first bit received.
- out_and, output, 1, AND of all out_data bits (registered with out_data).
- out_or, output, 1, OR of all out_data bits (registered with out_data).
- out_valid, output, 1, out_data/out_and/out_or are valid.
- out_ready, input, 1, consumer takes the word this cycle.
- par_err, output, 1, parity error flag; exists only with the optional feature.

Behaviour:
- Reset is asynchronous and active-low (rst_n), on the single clock clk. While rst_n=0:
  - out_data=0, out_and=0, out_or=0, out_valid=0, par_err=0.
  - Bit counter cnt=0, shift register cleared.
  - in_ready=1 once released.
- Accept rule: an input transfer occurs when in_valid && in_ready at a rising edge. Bit k of the word (k=cnt) is written to shift position k, then cnt increments.
- Two states, COLLECT and COMPLETE, encoded by cnt (0..LAST):
  - Without the optional feature, LAST=WIDTH-1.
  - COMPLETE is the transfer at cnt==LAST.
- Completion cycle:
  - The full word (including the bit arriving that cycle) loads into out_data.
  - out_and and out_or are computed from the loaded word and registered in the same edge.
  - out_valid is set to 1 and cnt wraps to 0.
  - Latency: out_valid rises on the edge that accepts the last bit, so it is visible in the following cycle.
- Output handshake:
  - The word is consumed when out_valid && out_ready; out_valid then clears next edge unless a new completion loads in the same edge.
  - out_data, out_and and out_or stay stable while out_valid=1 and out_ready=0.
- Backpressure:
  - in_ready=0 only when cnt==LAST && out_valid && !out_ready. In every other case in_ready=1.
  - Non-final bits are always accepted.
  - Simultaneous completion and consume is allowed: the new word replaces the old one and out_valid stays 1, giving zero-bubble throughput of one word per LAST+1 accepted bits.
- clr:
  - Sets cnt=0 and discards partial bits. Any in_bit in the same cycle is dropped, because clr has priority over input transfer.
  - out_valid and the held word are unaffected.
  - An out_ready handshake in the same cycle still completes.
- in_valid=0 cycles do not advance cnt, so gaps between bits are allowed.
- Reset mid-word: the partial word and any held output word are lost, and the first bit after reset is bit 0.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.

Optional Feature:
- Macro: DESER3_PARITY_EN.
- Defined:
  - LAST=WIDTH, i.e. one extra serial bit per word carrying even parity (XOR of data bits XOR parity bit must be 0).
  - The parity bit is not stored in out_data.
  - On completion, par_err is loaded with the XOR result and held together with the word. It follows the same stable/replace rules as out_data and clears on consume without a new load.
  - Backpressure applies at the parity-bit position.
  - clr discards a pending parity position.
- Undefined: LAST=WIDTH-1, the par_err port is absent, and no extra bit is consumed.

Test Plan:
- Reset then bits 1,0,1 with in_valid=1 and out_ready=1 -> after the third accept, out_valid=1, out_data=3'b101, out_and=0, out_or=1; the next cycle out_valid=0.
- Bits 1,1,1 with out_ready=0, then bits 0,0 -> out_data=3'b111 and out_and=1 held. Both bits 0,0 are accepted. in_ready=0 while the third bit is offered; raising out_ready accepts it in the same cycle, out_valid stays 1, and out_data becomes {x,0,0} with the correct value.
- Bits 1,0, then clr pulse with in_bit=1, then bits 0,1,1 -> word 3'b110; the 1 arriving with clr is discarded and out_or=1, out_and=0.
- Bits 0,0,0 with in_valid gaps of 3 cycles between bits -> out_data=0, out_or=0, and one out_valid pulse.
- rst_n pulled low after 2 bits, then released, then bits 1,1,1 -> out_valid=0 during reset; after release the word is 3'b111 with no residue.
- With DESER3_PARITY_EN: bits 1,0,1 + parity 0 -> par_err=0. Bits 1,0,0 + parity 0 -> par_err=1 and out_data=3'b001.

Source files
------------

// File: rtl/deser3.sv
// Serial-to-parallel word assembler, LSB first, with registered AND/OR reductions.
// Optional even-parity trailer bit and par_err output: define DESER3_PARITY_EN.
module deser3 #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_and,
    output logic             out_or,
    output logic             out_valid,
`ifdef DESER3_PARITY_EN
    output logic             par_err,
`endif
    input  logic             out_ready
);

`ifdef DESER3_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int CW = $clog2(LAST + 1);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] word;
    logic             take;
    logic             done;
`ifdef DESER3_PARITY_EN
    logic             perr;
`endif

    // cnt is the state: COLLECT below LAST, COMPLETE on the transfer at LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (take) begin
            cnt_d = done ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        in_ready = !((cnt_q == LAST_C) && out_valid && !out_ready);
        take     = in_valid && in_ready && !clr;
        done     = take && (cnt_q == LAST_C);
    end

    always_comb begin
        sh_d = sh_q;
        if (clr) begin
            sh_d = '0;
        end else if (take) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == CW'(i)) begin
                    sh_d[i] = in_bit;
                end
            end
        end
`ifdef DESER3_PARITY_EN
        // final bit is parity only; data bits are already in sh_q
        word = sh_q;
        perr = ^{sh_q, in_bit};
`else
        word = sh_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_and   <= 1'b0;
            out_or    <= 1'b0;
            out_valid <= 1'b0;
`ifdef DESER3_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else if (done) begin
            out_data  <= word;
            out_and   <= &word;
            out_or    <= |word;
            out_valid <= 1'b1;
`ifdef DESER3_PARITY_EN
            par_err   <= perr;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
`ifdef DESER3_PARITY_EN
            par_err   <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_deser3.sv
// Directed bench for deser3: per-cycle vector table plus reset/parity sequences.
// Vector fields: clr, bit, valid, out_ready | exp in_ready, out_valid, data, and, or.
module tb_deser3;

    typedef struct packed {
        logic       c;
        logic       b;
        logic       iv;
        logic       ordy;
        logic       erdy;
        logic       evld;
        logic [2:0] ed;
        logic       ea;
        logic       eo;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_data;
    logic       out_and;
    logic       out_or;
    logic       out_valid;
    logic       out_ready;
`ifdef DESER3_PARITY_EN
    logic       par_err;
`endif

    int passed = 0;
    int total  = 0;

    deser3 #(.WIDTH(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_and  (out_and),
        .out_or   (out_or),
        .out_valid(out_valid),
`ifdef DESER3_PARITY_EN
        .par_err  (par_err),
`endif
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input logic v, input logic [2:0] d,
                           input logic a, input logic o);
        chk("out_valid", 8'(out_valid), 8'(v));
        chk("out_data", 8'(out_data), 8'(d));
        chk("out_and", 8'(out_and), 8'(a));
        chk("out_or", 8'(out_or), 8'(o));
    endtask

    task automatic apply(input vec_t v);
        clr       = v.c;
        in_bit    = v.b;
        in_valid  = v.iv;
        out_ready = v.ordy;
        #1;
        chk("in_ready", 8'(in_ready), 8'(v.erdy));
        @(posedge clk);
        #1;
        chk_out(v.evld, v.ed, v.ea, v.eo);
    endtask

`ifndef DESER3_PARITY_EN
    vec_t tbl [31];
`endif

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        chk_out(1'b0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_rst", 8'(in_ready), 8'd1);

`ifndef DESER3_PARITY_EN
        tbl = '{
            11'b0_1_1_1_1_0_000_0_0,
            11'b0_0_1_1_1_0_000_0_0,
            11'b0_1_1_1_1_1_101_0_1,
            11'b0_0_0_1_1_0_101_0_1,
            11'b0_1_1_0_1_0_101_0_1,
            11'b0_1_1_0_1_0_101_0_1,
            11'b0_1_1_0_1_1_111_1_1,
            11'b0_0_1_0_1_1_111_1_1,
            11'b0_0_1_0_1_1_111_1_1,
            11'b0_1_1_0_0_1_111_1_1,
            11'b0_1_1_1_1_1_100_0_1,
            11'b0_0_0_1_1_0_100_0_1,
            11'b0_1_1_1_1_0_100_0_1,
            11'b0_0_1_1_1_0_100_0_1,
            11'b1_1_1_1_1_0_100_0_1,
            11'b0_0_1_1_1_0_100_0_1,
            11'b0_1_1_1_1_0_100_0_1,
            11'b0_1_1_1_1_1_110_0_1,
            11'b0_1_1_0_1_1_110_0_1,
            11'b1_0_0_0_1_1_110_0_1,
            11'b1_1_1_1_1_0_110_0_1,
            11'b0_0_1_1_1_0_110_0_1,
            11'b0_0_0_1_1_0_110_0_1,
            11'b0_0_0_1_1_0_110_0_1,
            11'b0_0_0_1_1_0_110_0_1,
            11'b0_0_1_1_1_0_110_0_1,
            11'b0_0_0_1_1_0_110_0_1,
            11'b0_0_0_1_1_0_110_0_1,
            11'b0_0_0_1_1_0_110_0_1,
            11'b0_0_1_1_1_1_000_0_0,
            11'b0_0_0_1_1_0_000_0_0
        };
        for (int i = 0; i < 31; i++) begin
            apply(tbl[i]);
        end

        // hold a word, start another, then reset mid-word
        apply(11'b0_1_1_0_1_0_000_0_0);
        apply(11'b0_1_1_0_1_0_000_0_0);
        apply(11'b0_1_1_0_1_1_111_1_1);
        apply(11'b0_1_1_0_1_1_111_1_1);
        apply(11'b0_1_1_0_1_1_111_1_1);
        #1;
        chk("in_ready_bp", 8'(in_ready), 8'd0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_out(1'b0, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("valid_in_rst", 8'(out_valid), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(11'b0_1_1_1_1_0_000_0_0);
        apply(11'b0_1_1_1_1_0_000_0_0);
        apply(11'b0_1_1_1_1_1_111_1_1);
        apply(11'b0_0_0_1_1_0_111_1_1);
`else
        apply(11'b0_1_1_1_1_0_000_0_0);
        apply(11'b0_0_1_1_1_0_000_0_0);
        apply(11'b0_1_1_1_1_0_000_0_0);
        apply(11'b0_0_1_1_1_1_101_0_1);
        chk("par_err_ok", 8'(par_err), 8'd0);
        apply(11'b0_1_1_1_1_0_101_0_1);
        apply(11'b0_0_1_1_1_0_101_0_1);
        apply(11'b0_0_1_1_1_0_101_0_1);
        apply(11'b0_0_1_1_1_1_001_0_1);
        chk("par_err_bad", 8'(par_err), 8'd1);
        apply(11'b0_0_0_1_1_0_001_0_1);
        chk("par_err_clr", 8'(par_err), 8'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
